// File: rtl/arb_egress_buffer.sv
// Two-entry skid buffer between a grant-driven arbiter and a ready/valid egress port.
// Tracks per-source delivered-packet counts and records dropped grants and bad grants in sticky flags.
module arb_egress_buffer #(
   parameter int NUM_REQS = 4,
   parameter int WIDTH    = 8,
   parameter int CWID     = 8,
   parameter int SWID     = $clog2(NUM_REQS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQS-1:0]        gnt,
   input  logic [NUM_REQS*WIDTH-1:0]  flat_data_in,
   input  logic                       out_ready,
   output logic                       out_vld,
   output logic [WIDTH-1:0]           out_data,
   output logic [SWID-1:0]            out_src,
   output logic                       blk,
   output logic                       ovf,
   output logic                       gnt_err,
   output logic [NUM_REQS*CWID-1:0]   flat_pkt_cnt
);

   // Entry 0 is always the head; entry 1 shifts down into it on pop.
   logic [1:0]       occ_r;
   logic [WIDTH-1:0] data_r [2];
   logic [SWID-1:0]  src_r  [2];
   logic             ovf_r;
   logic             gnt_err_r;

   logic             push_s;
   logic             pop_s;
   logic             multi_s;
   logic [SWID-1:0]  sel_s;
   logic [WIDTH-1:0] word_s;

   function automatic logic [SWID-1:0] lowest_idx(input logic [NUM_REQS-1:0] g);
      logic [SWID-1:0] idx;
      idx = '0;
      for (int i = NUM_REQS - 1; i >= 0; i--) begin
         if (g[i]) begin
            idx = SWID'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Push/pop decode, grant source selection and arbiter back-pressure.
   always_comb begin
      push_s  = |gnt;
      pop_s   = (occ_r != 2'd0) & out_ready;
      multi_s = (gnt & (gnt - NUM_REQS'(1))) != '0;
      sel_s   = lowest_idx(gnt);
      word_s  = flat_data_in[int'(sel_s)*WIDTH +: WIDTH];
      blk     = (occ_r == 2'd2) | ((occ_r == 2'd1) & ~out_ready);
   end

   // Buffer storage, occupancy and sticky error flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         occ_r     <= 2'd0;
         data_r[0] <= '0;
         data_r[1] <= '0;
         src_r[0]  <= '0;
         src_r[1]  <= '0;
         ovf_r     <= 1'b0;
         gnt_err_r <= 1'b0;
      end else begin
         if (multi_s) begin
            gnt_err_r <= 1'b1;
         end
         case ({push_s, pop_s})
            2'b10: begin
               case (occ_r)
                  2'd0: begin
                     data_r[0] <= word_s;
                     src_r[0]  <= sel_s;
                     occ_r     <= 2'd1;
                  end
                  2'd1: begin
                     data_r[1] <= word_s;
                     src_r[1]  <= sel_s;
                     occ_r     <= 2'd2;
                  end
                  default: begin
                     // Full with no pop: grant is lost, contents untouched.
                     ovf_r <= 1'b1;
                  end
               endcase
            end
            2'b01: begin
               data_r[0] <= data_r[1];
               src_r[0]  <= src_r[1];
               occ_r     <= occ_r - 2'd1;
            end
            2'b11: begin
               if (occ_r == 2'd1) begin
                  data_r[0] <= word_s;
                  src_r[0]  <= sel_s;
               end else begin
                  data_r[0] <= data_r[1];
                  src_r[0]  <= src_r[1];
                  data_r[1] <= word_s;
                  src_r[1]  <= sel_s;
               end
            end
            default: begin
               occ_r <= occ_r;
            end
         endcase
      end
   end

   for (genvar g = 0; g < NUM_REQS; g++) begin : g_cnt
      logic [CWID-1:0] cnt_r;

      // Per-source delivered-packet counter, wraps naturally.
      always_ff @(posedge clk) begin
         if (!rst) begin
            cnt_r <= '0;
         end else if (pop_s && (src_r[0] == SWID'(g))) begin
            cnt_r <= cnt_r + CWID'(1);
         end else begin
            cnt_r <= cnt_r;
         end
      end

      assign flat_pkt_cnt[g*CWID +: CWID] = cnt_r;
   end

   assign out_vld  = (occ_r != 2'd0);
   assign out_data = data_r[0];
   assign out_src  = src_r[0];
   assign ovf      = ovf_r;
   assign gnt_err  = gnt_err_r;

endmodule

// File: tb/tb_arb_egress_buffer.sv
// Directed bench for arb_egress_buffer: a vector table for single-cycle behaviour
// plus hand-written sequences for full-buffer, overflow, reset and counter-wrap cases.
module tb_arb_egress_buffer;

   logic        clk;
   logic        rst;
   logic [3:0]  gnt;
   logic [31:0] flat_data_in;
   logic        out_ready;
   logic        out_vld;
   logic [7:0]  out_data;
   logic [1:0]  out_src;
   logic        blk;
   logic        ovf;
   logic        gnt_err;
   logic [31:0] flat_pkt_cnt;

   int checks;
   int failures;

   arb_egress_buffer #(.NUM_REQS(4), .WIDTH(8), .CWID(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .gnt          (gnt),
      .flat_data_in (flat_data_in),
      .out_ready    (out_ready),
      .out_vld      (out_vld),
      .out_data     (out_data),
      .out_src      (out_src),
      .blk          (blk),
      .ovf          (ovf),
      .gnt_err      (gnt_err),
      .flat_pkt_cnt (flat_pkt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  gnt;
      logic [31:0] flat;
      logic        rdy;
      logic        vld;
      logic        chk_data;
      logic [7:0]  data;
      logic [1:0]  src;
      logic        blk;
      logic [1:0]  occ;
      logic        err;
   } vec_t;

   vec_t tbl [10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] cnt(input int i);
      return flat_pkt_cnt[i*8 +: 8];
   endfunction

   initial begin
      checks       = 0;
      failures     = 0;
      rst          = 1'b0;
      gnt          = 4'b0000;
      flat_data_in = 32'h0000_0000;
      out_ready    = 1'b0;

      //              gnt      flat           rdy   vld   chkd  data   src   blk   occ   err
      tbl[0] = '{4'b0010, 32'h0000_A500, 1'b1, 1'b1, 1'b1, 8'hA5, 2'd1, 1'b0, 2'd1, 1'b0};
      tbl[1] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 1'b0};
      tbl[2] = '{4'b0001, 32'h0000_003C, 1'b0, 1'b1, 1'b1, 8'h3C, 2'd0, 1'b1, 2'd1, 1'b0};
      tbl[3] = '{4'b1000, 32'h7E00_0000, 1'b0, 1'b1, 1'b1, 8'h3C, 2'd0, 1'b1, 2'd2, 1'b0};
      tbl[4] = '{4'b0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 8'h3C, 2'd0, 1'b1, 2'd2, 1'b0};
      tbl[5] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 8'h7E, 2'd3, 1'b0, 2'd1, 1'b0};
      tbl[6] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 1'b0};
      tbl[7] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 1'b0};
      tbl[8] = '{4'b0110, 32'h0099_5A00, 1'b0, 1'b1, 1'b1, 8'h5A, 2'd1, 1'b1, 2'd1, 1'b1};
      tbl[9] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 1'b1};

      step();
      step();
      chk("rst_vld", 32'(out_vld), 32'd0);
      chk("rst_occ", 32'(dut.occ_r), 32'd0);
      chk("rst_flags", {30'd0, ovf, gnt_err}, 32'd0);
      chk("rst_cnt", flat_pkt_cnt, 32'd0);
      rst = 1'b1;

      for (int v = 0; v < 10; v++) begin
         gnt          = tbl[v].gnt;
         flat_data_in = tbl[v].flat;
         out_ready    = tbl[v].rdy;
         step();
         chk($sformatf("tbl%0d_vld", v), 32'(out_vld), 32'(tbl[v].vld));
         chk($sformatf("tbl%0d_occ", v), 32'(dut.occ_r), 32'(tbl[v].occ));
         chk($sformatf("tbl%0d_blk", v), 32'(blk), 32'(tbl[v].blk));
         chk($sformatf("tbl%0d_err", v), 32'(gnt_err), 32'(tbl[v].err));
         chk($sformatf("tbl%0d_ovf", v), 32'(ovf), 32'd0);
         if (tbl[v].chk_data) begin
            chk($sformatf("tbl%0d_data", v), 32'(out_data), 32'(tbl[v].data));
            chk($sformatf("tbl%0d_src", v), 32'(out_src), 32'(tbl[v].src));
         end
      end
      chk("tbl_cnt0", 32'(cnt(0)), 32'd1);
      chk("tbl_cnt1", 32'(cnt(1)), 32'd2);
      chk("tbl_cnt2", 32'(cnt(2)), 32'd0);
      chk("tbl_cnt3", 32'(cnt(3)), 32'd1);

      // Full buffer with simultaneous push and pop.
      gnt = 4'b0001; flat_data_in = 32'h0000_0011; out_ready = 1'b0;
      step();
      gnt = 4'b0010; flat_data_in = 32'h0000_2200;
      step();
      chk("pp_full_occ", 32'(dut.occ_r), 32'd2);
      chk("pp_full_blk", 32'(blk), 32'd1);
      gnt = 4'b1000; flat_data_in = 32'h4400_0000; out_ready = 1'b1;
      step();
      chk("pp_occ", 32'(dut.occ_r), 32'd2);
      chk("pp_ovf", 32'(ovf), 32'd0);
      chk("pp_head_data", 32'(out_data), 32'h22);
      chk("pp_head_src", 32'(out_src), 32'd1);
      gnt = 4'b0000; flat_data_in = 32'h0000_0000;
      step();
      chk("pp_next_data", 32'(out_data), 32'h44);
      chk("pp_next_src", 32'(out_src), 32'd3);
      chk("pp_next_occ", 32'(dut.occ_r), 32'd1);
      step();
      chk("pp_empty_vld", 32'(out_vld), 32'd0);
      chk("pp_cnt0", 32'(cnt(0)), 32'd2);
      chk("pp_cnt1", 32'(cnt(1)), 32'd3);
      chk("pp_cnt3", 32'(cnt(3)), 32'd2);

      // Overflow: third grant with no pop is dropped.
      out_ready = 1'b0;
      gnt = 4'b0001; flat_data_in = 32'h0000_0011;
      step();
      chk("ov_blk1", 32'(blk), 32'd1);
      chk("ov_occ1", 32'(dut.occ_r), 32'd1);
      gnt = 4'b0010; flat_data_in = 32'h0000_2200;
      step();
      chk("ov_occ2", 32'(dut.occ_r), 32'd2);
      gnt = 4'b0100; flat_data_in = 32'h0033_0000;
      step();
      chk("ov_flag", 32'(ovf), 32'd1);
      chk("ov_occ", 32'(dut.occ_r), 32'd2);
      chk("ov_data", 32'(out_data), 32'h11);
      gnt = 4'b0000; flat_data_in = 32'h0000_0000;
      step();
      chk("ov_hold_data", 32'(out_data), 32'h11);
      chk("ov_hold_src", 32'(out_src), 32'd0);
      chk("ov_sticky", 32'(ovf), 32'd1);

      // Reset while full with a simultaneous grant.
      rst = 1'b0; gnt = 4'b0001; flat_data_in = 32'h0000_0077; out_ready = 1'b1;
      step();
      rst = 1'b1; gnt = 4'b0000; flat_data_in = 32'h0000_0000;
      chk("rr_vld", 32'(out_vld), 32'd0);
      chk("rr_occ", 32'(dut.occ_r), 32'd0);
      chk("rr_ovf", 32'(ovf), 32'd0);
      chk("rr_err", 32'(gnt_err), 32'd0);
      chk("rr_cnt", flat_pkt_cnt, 32'd0);
      chk("rr_data", {22'd0, out_src, out_data}, 32'd0);
      step();
      chk("rr_nosurvive", 32'(out_vld), 32'd0);

      // Source-3 counter wrap over 256 deliveries.
      out_ready = 1'b1;
      for (int n = 0; n < 256; n++) begin
         gnt = 4'b1000;
         flat_data_in = {8'(n), 24'h0};
         step();
         chk($sformatf("wr_data%0d", n), 32'(out_data), 32'(n));
      end
      chk("wr_cnt255", 32'(cnt(3)), 32'd255);
      chk("wr_ovf", 32'(ovf), 32'd0);
      gnt = 4'b0000; flat_data_in = 32'h0000_0000;
      step();
      chk("wr_cnt_wrap", 32'(cnt(3)), 32'd0);
      chk("wr_empty", 32'(out_vld), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arb_egress_buffer.md
ARB_EGRESS_BUFFER -- requirements
Module: arb_egress_buffer

Interface
REQ-001 The block SHALL have the parameter NUM_REQS, default 4, meaning the number of requestor FIFOs behind the arbiter.
REQ-002 The block SHALL have the parameter WIDTH, default 8, meaning the packet data width in bits.
REQ-003 The block SHALL have the parameter CWID, default 8, meaning the width of each per-source delivery counter.
REQ-004 The block SHALL have the parameter SWID, default $clog2(NUM_REQS), meaning the width of the source index.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have the port rst, input, 1 bit: the reset, which is synchronous and active-low.
REQ-007 The block SHALL have the port gnt, input, NUM_REQS bits: the arbiter grant, one bit per FIFO, nominally one-hot.
REQ-008 The block SHALL have the port flat_data_in, input, NUM_REQS*WIDTH bits: the FIFO data_out words, with word i at [(i+1)*WIDTH-1:i*WIDTH].
REQ-009 The block SHALL have the port out_ready, input, 1 bit: downstream ready.
REQ-010 The block SHALL have the port out_vld, output, 1 bit: the head entry is valid.
REQ-011 The block SHALL have the port out_data, output, WIDTH bits: the head entry data.
REQ-012 The block SHALL have the port out_src, output, SWID bits: the FIFO index the head entry came from.
REQ-013 The block SHALL have the port blk, output, 1 bit: the back-pressure signal to the arbiter blk input.
REQ-014 The block SHALL have the port ovf, output, 1 bit: sticky, set when a grant was dropped.
REQ-015 The block SHALL have the port gnt_err, output, 1 bit: sticky, set when a non-one-hot grant was seen.
REQ-016 The block SHALL have the port flat_pkt_cnt, output, NUM_REQS*CWID bits: the per-source delivered-packet counters, with source i at [(i+1)*CWID-1:i*CWID].

Function
REQ-017 The storage SHALL be a 2-entry FIFO (skid buffer) of {src, data}, with an occupancy count occ in 0..2.
REQ-018 push SHALL equal |gnt; pop SHALL equal out_vld & out_ready.
REQ-019 On push, the entry SHALL capture the lowest-index set bit k of gnt: src=k, data=word k of flat_data_in sampled the same cycle.
REQ-020 A pushed entry SHALL be visible on out_data/out_src no earlier than the next cycle (1-cycle latency through an empty buffer).
REQ-021 out_vld SHALL equal (occ>0); out_data/out_src SHALL present the oldest entry, in grant order.
REQ-022 When push and pop occur in the same cycle, both SHALL take effect and occ SHALL be unchanged, including when occ==2.
REQ-023 When push occurs with occ==2 and no pop, the grant SHALL be dropped, occ and contents SHALL be unchanged, and ovf SHALL be set.
REQ-024 blk SHALL be combinational: blk = (occ==2) | ((occ==1) & ~out_ready).
REQ-025 When gnt has two or more bits set, gnt_err SHALL be set, and the push SHALL still proceed per REQ-019.
REQ-026 On each pop, the counter of the popped entry's src SHALL increment by 1, wrapping modulo 2^CWID.
REQ-027 When out_vld is 0, out_ready SHALL have no effect.
REQ-028 While out_vld==1 and out_ready==0, out_data/out_src SHALL hold stable.

Reset
REQ-029 When rst==0 at a rising edge, occ, out_vld, out_data, out_src, ovf, gnt_err and all counters SHALL become 0.
REQ-030 Reset SHALL take priority over any push or pop in the same cycle, and no packet accepted in that cycle SHALL survive.
REQ-031 ovf and gnt_err SHALL clear only by reset.

Verification
REQ-032 A bench SHALL drive gnt=0010 with word1=0xA5 and out_ready=1; next cycle out_vld=1, out_data=0xA5, out_src=1; after the pop, counter1=1.
REQ-033 A bench SHALL hold out_ready=0 and grant 0x11 then 0x22; blk=1 after the first push, occ=2; a third grant 0x33 sets ovf=1 and out_data stays 0x11.
REQ-034 With occ=2, a bench SHALL drive a grant and out_ready=1 in the same cycle; ovf stays 0, occ stays 2, and the order is the 2nd entry then the new entry.
REQ-035 A bench SHALL drive gnt=0110; gnt_err=1, and the entry has src=1 with data=word1.
REQ-036 A bench SHALL deliver 256 packets from source 3 with CWID=8; counter3 wraps to 0.
REQ-037 A bench SHALL pulse rst=0 with occ=2 and a simultaneous grant; the next cycle shows out_vld=0, occ=0, and all flags and counters 0.
